instruction_fetch: RTL and testbench

Front-end stage of the 16-bit processor, directly upstream of the instruction decoder. It holds the fetch program counter and issues single-outstanding read requests to instruction memory. Each returned word is presented to the decoder through a valid/ready register slot with a one-entry buffer. It accepts branch redirects from later stages and discards any fetch already in flight.

---
 rtl/instruction_fetch_pkg.sv | 23 ++
 rtl/instruction_fetch_if.sv | 25 ++
 rtl/instruction_fetch_fetch_slot.sv | 57 +++++
 rtl/instruction_fetch.sv | 120 ++++++++++++
 tb/tb_instruction_fetch.sv | 252 +++++++++++++++++++++++++
 5 files changed

// File: rtl/instruction_fetch_pkg.sv
// Shared front-end definitions: fetch FSM states, reset vector and the
// branch-class opcode set also used by the instruction decoder.
package instruction_fetch_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        STALL = 2'd2,
        FLUSH = 2'd3
    } state_t;

    localparam logic [15:0] RESET_VECTOR_DEFAULT = 16'h0000;

    localparam logic [3:0] OP_BR_ZERO  = 4'b0000;
    localparam logic [3:0] OP_BR_FIRST = 4'b1011;
    localparam logic [3:0] OP_BR_LAST  = 4'b1110;

    function automatic logic is_branch_op(input logic [3:0] opcode);
        return (opcode == OP_BR_ZERO) ||
               ((opcode >= OP_BR_FIRST) && (opcode <= OP_BR_LAST));
    endfunction

endpackage

// File: rtl/instruction_fetch_if.sv
// Instruction memory read bus: single outstanding request, ack carries data.
interface instruction_fetch_if #(
    parameter int WIDTH = 16
) ();

    logic             imem_req;
    logic [WIDTH-1:0] imem_addr;
    logic             imem_ack;
    logic [WIDTH-1:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ack,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ack,
        output imem_rdata
    );

endinterface

// File: rtl/instruction_fetch_fetch_slot.sv
// Decoder-facing output register with a one-entry overflow buffer.
// Writes land in the output when it is free, otherwise in the buffer.
module fetch_slot #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_instr,
    input  logic [WIDTH-1:0] wr_pc,
    output logic [WIDTH-1:0] out_instr,
    output logic [WIDTH-1:0] out_pc,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             free
);

    logic             buf_valid;
    logic [WIDTH-1:0] buf_instr;
    logic [WIDTH-1:0] buf_pc;

    assign free = !out_valid || out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_instr <= '0;
            out_pc    <= '0;
            out_valid <= 1'b0;
            buf_instr <= '0;
            buf_pc    <= '0;
            buf_valid <= 1'b0;
        end else if (flush) begin
            out_valid <= 1'b0;
            buf_valid <= 1'b0;
        end else begin
            if (wr_en && free) begin
                out_instr <= wr_instr;
                out_pc    <= wr_pc;
                out_valid <= 1'b1;
            end else if (buf_valid && free) begin
                out_instr <= buf_instr;
                out_pc    <= buf_pc;
                out_valid <= 1'b1;
                buf_valid <= 1'b0;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
            if (wr_en && !free) begin
                buf_instr <= wr_instr;
                buf_pc    <= wr_pc;
                buf_valid <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage: program counter, single-outstanding imem requests, branch
// redirect with flush of the in-flight fetch, and halt at request boundaries.
module instruction_fetch
    import instruction_fetch_pkg::*;
#(
    parameter int               WIDTH        = 16,
    parameter logic [WIDTH-1:0] RESET_VECTOR = RESET_VECTOR_DEFAULT
) (
    input  logic                clk,
    input  logic                rst_n,
    instruction_fetch_if.master imem,
    output logic [WIDTH-1:0]    INSTR,
    output logic [WIDTH-1:0]    INSTR_PC,
    output logic                instr_valid,
    input  logic                instr_ready,
    input  logic                redirect,
    input  logic [WIDTH-1:0]    redirect_target,
    input  logic                halt
);

    state_t           state;
    logic             req_q;
    logic [WIDTH-1:0] addr_q;
    logic [WIDTH-1:0] fetch_pc;
    logic [WIDTH-1:0] pc_inc;
    logic [WIDTH-1:0] next_pc;
    logic             slot_free;
    logic             slot_wr;

    assign imem.imem_req  = req_q;
    assign imem.imem_addr = addr_q;
    assign pc_inc  = fetch_pc + WIDTH'(1);
    assign next_pc = redirect ? redirect_target : fetch_pc;
    assign slot_wr = (state == REQ) && imem.imem_ack && !redirect;

    fetch_slot #(
        .WIDTH (WIDTH)
    ) u_slot (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (redirect),
        .wr_en     (slot_wr),
        .wr_instr  (imem.imem_rdata),
        .wr_pc     (addr_q),
        .out_instr (INSTR),
        .out_pc    (INSTR_PC),
        .out_valid (instr_valid),
        .out_ready (instr_ready),
        .free      (slot_free)
    );

    // addr_q is decoupled from fetch_pc so FLUSH can hold the stale address
    // until its ack while fetch_pc already tracks the newest redirect target.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            fetch_pc <= RESET_VECTOR;
            req_q    <= 1'b0;
            addr_q   <= RESET_VECTOR;
        end else begin
            if (redirect) begin
                fetch_pc <= redirect_target;
            end
            case (state)
                IDLE: begin
                    if (!halt) begin
                        state  <= REQ;
                        req_q  <= 1'b1;
                        addr_q <= next_pc;
                    end
                end
                STALL: begin
                    if (redirect || slot_free) begin
                        state <= halt ? IDLE : REQ;
                        req_q <= !halt;
                        if (!halt) begin
                            addr_q <= next_pc;
                        end
                    end
                end
                REQ: begin
                    if (imem.imem_ack) begin
                        if (redirect) begin
                            addr_q <= redirect_target;
                        end else begin
                            fetch_pc <= pc_inc;
                            if (!slot_free) begin
                                state <= STALL;
                                req_q <= 1'b0;
                            end else if (halt) begin
                                state <= IDLE;
                                req_q <= 1'b0;
                            end else begin
                                addr_q <= pc_inc;
                            end
                        end
                    end else if (redirect) begin
                        state <= FLUSH;
                    end
                end
                FLUSH: begin
                    if (imem.imem_ack) begin
                        if (halt && !redirect) begin
                            state <= IDLE;
                            req_q <= 1'b0;
                        end else begin
                            state  <= REQ;
                            addr_q <= next_pc;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    req_q <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch: vector table for streaming, stalls,
// redirect-with-ack and halt, plus sequences for wait-state flush, reset, wrap.
module tb_instruction_fetch;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] INSTR, INSTR_PC;
    logic        instr_valid, instr_ready, redirect, halt;
    logic [15:0] redirect_target;
    logic [3:0]  mem_wait, wcnt;

    logic [15:0] instr2, pc2;
    logic        valid2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    instruction_fetch_if #(.WIDTH(16)) bus ();
    instruction_fetch_if #(.WIDTH(16)) bus2 ();

    instruction_fetch #(
        .WIDTH        (16),
        .RESET_VECTOR (16'h0000)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .imem            (bus),
        .INSTR           (INSTR),
        .INSTR_PC        (INSTR_PC),
        .instr_valid     (instr_valid),
        .instr_ready     (instr_ready),
        .redirect        (redirect),
        .redirect_target (redirect_target),
        .halt            (halt)
    );

    instruction_fetch #(
        .WIDTH        (16),
        .RESET_VECTOR (16'hFFFF)
    ) dut_wrap (
        .clk             (clk),
        .rst_n           (rst_n),
        .imem            (bus2),
        .INSTR           (instr2),
        .INSTR_PC        (pc2),
        .instr_valid     (valid2),
        .instr_ready     (1'b1),
        .redirect        (1'b0),
        .redirect_target (16'h0000),
        .halt            (1'b0)
    );

    // Memory returns address+0x1000 after mem_wait wait cycles.
    assign bus.imem_ack   = bus.imem_req && (wcnt == mem_wait);
    assign bus.imem_rdata = bus.imem_addr + 16'h1000;
    assign bus2.imem_ack   = bus2.imem_req;
    assign bus2.imem_rdata = bus2.imem_addr + 16'h1000;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) wcnt <= '0;
        else if (bus.imem_req && !bus.imem_ack) wcnt <= wcnt + 4'd1;
        else wcnt <= '0;
    end

    typedef struct {
        logic        ready;
        logic        halt;
        logic        redir;
        logic [15:0] target;
        logic        exp_valid;
        logic [15:0] exp_instr;
        logic [15:0] exp_pc;
        logic        exp_req;
        logic [15:0] exp_addr;
    } vec_t;

    vec_t vecs[15];

    function automatic vec_t mk(input logic rdy, input logic hlt, input logic rd,
                                input logic [15:0] tgt, input logic v,
                                input logic [15:0] ins, input logic [15:0] pc,
                                input logic rq, input logic [15:0] ad);
        vec_t r;
        r.ready = rdy; r.halt = hlt; r.redir = rd; r.target = tgt;
        r.exp_valid = v; r.exp_instr = ins; r.exp_pc = pc;
        r.exp_req = rq; r.exp_addr = ad;
        return r;
    endfunction

    task automatic check16(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset(input logic [3:0] w);
        rst_n = 1'b0;
        mem_wait = w;
        instr_ready = 1'b1;
        halt = 1'b0;
        redirect = 1'b0;
        redirect_target = 16'h0000;
        step();
        step();
        rst_n = 1'b1;
    endtask

    logic [15:0] n;

    initial begin
        vecs[0]  = mk(1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 16'h0000, 1'b1, 16'h0000);
        vecs[1]  = mk(1'b1, 1'b0, 1'b0, 16'h0000, 1'b1, 16'h1000, 16'h0000, 1'b1, 16'h0001);
        vecs[2]  = mk(1'b1, 1'b0, 1'b0, 16'h0000, 1'b1, 16'h1001, 16'h0001, 1'b1, 16'h0002);
        vecs[3]  = mk(1'b1, 1'b0, 1'b0, 16'h0000, 1'b1, 16'h1002, 16'h0002, 1'b1, 16'h0003);
        vecs[4]  = mk(1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 16'h1002, 16'h0002, 1'b0, 16'h0003);
        vecs[5]  = mk(1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 16'h1002, 16'h0002, 1'b0, 16'h0003);
        vecs[6]  = mk(1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 16'h1002, 16'h0002, 1'b0, 16'h0003);
        vecs[7]  = mk(1'b1, 1'b0, 1'b0, 16'h0000, 1'b1, 16'h1003, 16'h0003, 1'b1, 16'h0004);
        vecs[8]  = mk(1'b1, 1'b0, 1'b0, 16'h0000, 1'b1, 16'h1004, 16'h0004, 1'b1, 16'h0005);
        vecs[9]  = mk(1'b1, 1'b0, 1'b1, 16'h0100, 1'b0, 16'h0000, 16'h0000, 1'b1, 16'h0100);
        vecs[10] = mk(1'b1, 1'b0, 1'b0, 16'h0000, 1'b1, 16'h1100, 16'h0100, 1'b1, 16'h0101);
        vecs[11] = mk(1'b1, 1'b1, 1'b0, 16'h0000, 1'b1, 16'h1101, 16'h0101, 1'b0, 16'h0101);
        vecs[12] = mk(1'b1, 1'b1, 1'b0, 16'h0000, 1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0101);
        vecs[13] = mk(1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 16'h0000, 1'b1, 16'h0102);
        vecs[14] = mk(1'b1, 1'b0, 1'b0, 16'h0000, 1'b1, 16'h1102, 16'h0102, 1'b1, 16'h0103);

        // Reset state
        rst_n = 1'b0;
        mem_wait = 4'd0;
        instr_ready = 1'b1;
        halt = 1'b0;
        redirect = 1'b0;
        redirect_target = 16'h0000;
        step();
        step();
        check1 ("rst req",   bus.imem_req, 1'b0);
        check16("rst addr",  bus.imem_addr, 16'h0000);
        check16("rst instr", INSTR, 16'h0000);
        check16("rst pc",    INSTR_PC, 16'h0000);
        check1 ("rst valid", instr_valid, 1'b0);
        check16("rst addr wrap dut", bus2.imem_addr, 16'hFFFF);
        rst_n = 1'b1;

        for (int i = 0; i < 15; i++) begin
            instr_ready     = vecs[i].ready;
            halt            = vecs[i].halt;
            redirect        = vecs[i].redir;
            redirect_target = vecs[i].target;
            step();
            check1 ($sformatf("v%0d valid", i), instr_valid, vecs[i].exp_valid);
            check1 ($sformatf("v%0d req", i), bus.imem_req, vecs[i].exp_req);
            check16($sformatf("v%0d addr", i), bus.imem_addr, vecs[i].exp_addr);
            if (vecs[i].exp_valid) begin
                check16($sformatf("v%0d instr", i), INSTR, vecs[i].exp_instr);
                check16($sformatf("v%0d pc", i), INSTR_PC, vecs[i].exp_pc);
            end
        end
        redirect = 1'b0;
        halt = 1'b0;

        // Redirect during the first wait cycle of a 2-wait fetch
        do_reset(4'd2);
        step();
        check1 ("A req", bus.imem_req, 1'b1);
        check16("A addr0", bus.imem_addr, 16'h0000);
        redirect = 1'b1;
        redirect_target = 16'h0040;
        step();
        redirect = 1'b0;
        check1 ("A flush req", bus.imem_req, 1'b1);
        check16("A flush addr", bus.imem_addr, 16'h0000);
        check1 ("A flush valid", instr_valid, 1'b0);
        step();
        check16("A hold addr", bus.imem_addr, 16'h0000);
        check1 ("A hold valid", instr_valid, 1'b0);
        step();
        check16("A target addr", bus.imem_addr, 16'h0040);
        check1 ("A target req", bus.imem_req, 1'b1);
        check1 ("A discard valid", instr_valid, 1'b0);
        n = 16'd0;
        while (!instr_valid && n < 16'd10) begin
            step();
            n++;
        end
        check16("A latency", n, 16'd3);
        check16("A instr", INSTR, 16'h1040);
        check16("A pc", INSTR_PC, 16'h0040);

        // halt during a 3-wait fetch, then asynchronous reset mid-request
        do_reset(4'd3);
        step();
        check1("B req", bus.imem_req, 1'b1);
        halt = 1'b1;
        n = 16'd0;
        while (!instr_valid && n < 16'd10) begin
            step();
            n++;
        end
        instr_ready = 1'b0;
        check16("B latency", n, 16'd4);
        check16("B instr", INSTR, 16'h1000);
        check1 ("B req after halt", bus.imem_req, 1'b0);
        for (int i = 0; i < 4; i++) begin
            step();
            check1($sformatf("B halted req %0d", i), bus.imem_req, 1'b0);
        end
        halt = 1'b0;
        step();
        check1 ("B resume req", bus.imem_req, 1'b1);
        check16("B resume addr", bus.imem_addr, 16'h0001);
        check1 ("B held valid", instr_valid, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        check1 ("B async req", bus.imem_req, 1'b0);
        check16("B async addr", bus.imem_addr, 16'h0000);
        check1 ("B async valid", instr_valid, 1'b0);
        check16("B async instr", INSTR, 16'h0000);
        check16("B async pc", INSTR_PC, 16'h0000);

        // RESET_VECTOR = 0xFFFF wraps to 0x0000
        do_reset(4'd0);
        step();
        step();
        check1 ("C valid0", valid2, 1'b1);
        check16("C pc0", pc2, 16'hFFFF);
        check16("C instr0", instr2, 16'h0FFF);
        step();
        check16("C pc1", pc2, 16'h0000);
        check16("C instr1", instr2, 16'h1000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
